// File: rtl/dm_cache_controller.sv
// Direct-mapped, write-back, write-allocate cache controller with one-word lines.
// Optional DM_CACHE_STATS_EN adds saturating hit_count / miss_count outputs.
// Bus packing: cache_to_mem = {addr, data[32], rw, valid}; mem_to_cache = {data[32], ready}.
module dm_cache_controller #(
    parameter int ADDR_BITS  = 20,
    parameter int INDEX_BITS = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req_valid,
    input  logic                  cpu_req_rw,
    input  logic [ADDR_BITS-1:0]  cpu_req_addr,
    input  logic [31:0]           cpu_req_data,
    output logic [31:0]           cpu_res_data,
    output logic                  cpu_res_ready,
    output logic [ADDR_BITS+33:0] cache_to_mem,
    input  logic [32:0]           mem_to_cache
`ifdef DM_CACHE_STATS_EN
    ,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
`endif
);

    localparam int TAG_BITS = ADDR_BITS - INDEX_BITS;
    localparam int LINES    = 1 << INDEX_BITS;

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_COMPARE    = 2'd1,
        S_WRITE_BACK = 2'd2,
        S_ALLOCATE   = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic                   req_rw_q, req_rw_d;
    logic [ADDR_BITS-1:0]   req_addr_q, req_addr_d;
    logic [31:0]            req_data_q, req_data_d;
    logic [LINES-1:0]       valid_q, valid_d;
    logic [LINES-1:0]       dirty_q, dirty_d;
    logic [31:0]            res_data_q, res_data_d;
    logic                   res_ready_q, res_ready_d;
    logic [ADDR_BITS-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]            mem_data_q, mem_data_d;
    logic                   mem_rw_q, mem_rw_d;
    logic                   mem_valid_q, mem_valid_d;

    logic [TAG_BITS-1:0]    tag_mem [LINES];
    logic [31:0]            data_mem [LINES];

    logic [INDEX_BITS-1:0]  idx_s;
    logic [TAG_BITS-1:0]    tag_s;
    logic [TAG_BITS-1:0]    cur_tag_s;
    logic [31:0]            cur_line_s;
    logic                   hit_s;
    logic                   mem_ready_s;
    logic [31:0]            mem_rdata_s;
    logic                   line_we_s;
    logic [31:0]            line_data_s;

    assign idx_s       = req_addr_q[INDEX_BITS-1:0];
    assign tag_s       = req_addr_q[ADDR_BITS-1:INDEX_BITS];
    assign cur_tag_s   = tag_mem[idx_s];
    assign cur_line_s  = data_mem[idx_s];
    assign hit_s       = valid_q[idx_s] && (cur_tag_s == tag_s);
    assign mem_ready_s = mem_to_cache[0];
    assign mem_rdata_s = mem_to_cache[32:1];

    // State and control register bank
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            req_rw_q    <= 1'b0;
            req_addr_q  <= '0;
            req_data_q  <= 32'd0;
            valid_q     <= '0;
            dirty_q     <= '0;
            res_data_q  <= 32'd0;
            res_ready_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_data_q  <= 32'd0;
            mem_rw_q    <= 1'b0;
            mem_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_rw_q    <= req_rw_d;
            req_addr_q  <= req_addr_d;
            req_data_q  <= req_data_d;
            valid_q     <= valid_d;
            dirty_q     <= dirty_d;
            res_data_q  <= res_data_d;
            res_ready_q <= res_ready_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            mem_rw_q    <= mem_rw_d;
            mem_valid_q <= mem_valid_d;
        end
    end

    // Tag/data storage; contents are meaningless until the valid bit is set
    always_ff @(posedge clk) begin
        if (line_we_s) begin
            tag_mem[idx_s]  <= tag_s;
            data_mem[idx_s] <= line_data_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (cpu_req_valid) state_d = S_COMPARE;
                else               state_d = S_IDLE;
            end
            S_COMPARE: begin
                if (hit_s)                                 state_d = S_IDLE;
                else if (valid_q[idx_s] && dirty_q[idx_s]) state_d = S_WRITE_BACK;
                else                                       state_d = S_ALLOCATE;
            end
            S_WRITE_BACK: begin
                if (mem_ready_s) state_d = S_ALLOCATE;
                else             state_d = S_WRITE_BACK;
            end
            S_ALLOCATE: begin
                if (mem_ready_s) state_d = S_COMPARE;
                else             state_d = S_ALLOCATE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath, array updates and registered outputs per state
    always_comb begin
        req_rw_d    = req_rw_q;
        req_addr_d  = req_addr_q;
        req_data_d  = req_data_q;
        valid_d     = valid_q;
        dirty_d     = dirty_q;
        res_data_d  = res_data_q;
        res_ready_d = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        mem_rw_d    = mem_rw_q;
        mem_valid_d = 1'b0;
        line_we_s   = 1'b0;
        line_data_s = req_data_q;
        case (state_q)
            S_IDLE: begin
                if (cpu_req_valid) begin
                    req_rw_d   = cpu_req_rw;
                    req_addr_d = cpu_req_addr;
                    req_data_d = cpu_req_data;
                end else begin
                    req_rw_d = req_rw_q;
                end
            end
            S_COMPARE: begin
                if (hit_s) begin
                    res_ready_d = 1'b1;
                    if (req_rw_q) begin
                        line_we_s      = 1'b1;
                        dirty_d[idx_s] = 1'b1;
                    end else begin
                        res_data_d = cur_line_s;
                    end
                end else if (valid_q[idx_s] && dirty_q[idx_s]) begin
                    mem_addr_d  = {cur_tag_s, idx_s};
                    mem_data_d  = cur_line_s;
                    mem_rw_d    = 1'b1;
                    mem_valid_d = 1'b1;
                end else begin
                    mem_addr_d  = req_addr_q;
                    mem_rw_d    = 1'b0;
                    mem_valid_d = 1'b1;
                end
            end
            S_WRITE_BACK: begin
                if (mem_ready_s) begin
                    dirty_d[idx_s] = 1'b0;
                    mem_addr_d     = req_addr_q;
                    mem_rw_d       = 1'b0;
                    mem_valid_d    = 1'b1;
                end else begin
                    mem_valid_d = 1'b0;
                end
            end
            S_ALLOCATE: begin
                if (mem_ready_s) begin
                    line_we_s      = 1'b1;
                    line_data_s    = mem_rdata_s;
                    valid_d[idx_s] = 1'b1;
                    dirty_d[idx_s] = 1'b0;
                end else begin
                    line_we_s = 1'b0;
                end
            end
            default: begin
                res_ready_d = 1'b0;
            end
        endcase
    end

    assign cpu_res_data  = res_data_q;
    assign cpu_res_ready = res_ready_q;
    assign cache_to_mem  = {mem_addr_q, mem_data_q, mem_rw_q, mem_valid_q};

`ifdef DM_CACHE_STATS_EN
    logic        first_q, first_d;
    logic [31:0] hit_count_q, hit_count_d;
    logic [31:0] miss_count_q, miss_count_d;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Only the first COMPARE of a request is counted, not the post-refill one
    always_comb begin
        first_d      = first_q;
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (state_q == S_IDLE && cpu_req_valid) begin
            first_d = 1'b1;
        end else if (state_q == S_COMPARE) begin
            first_d = 1'b0;
            if (first_q && hit_s)       hit_count_d  = sat_inc(hit_count_q);
            else if (first_q)           miss_count_d = sat_inc(miss_count_q);
            else                        hit_count_d  = hit_count_q;
        end else begin
            first_d = first_q;
        end
    end

    // Statistics registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            first_q      <= 1'b0;
            hit_count_q  <= 32'd0;
            miss_count_q <= 32'd0;
        end else begin
            first_q      <= first_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule

// File: doc/dm_cache_controller.md
Name: dm_cache_controller

Overview:
- Cache-side initiator for the cache_to_mem / mem_to_cache protocol. It is the direct-mapped, write-back, write-allocate cache that sits between the CPU and the synchronous byte-write RAM controller.
- Serves CPU word reads and writes from an internal tag/valid/dirty/data array.
- On a miss it evicts a dirty victim, then refills the line over the memory interface.
- Line size is one 32-bit word (cache_data_type).

Parameters:
- ADDR_BITS, 20, word-address width; must equal the memory addr field width.
- INDEX_BITS, 10, index width; the array holds 2^INDEX_BITS lines; tag width = ADDR_BITS-INDEX_BITS.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- cpu_req_valid  in  1  CPU request strobe; sampled only in IDLE.
- cpu_req_rw  in  1  1 = write, 0 = read.
- cpu_req_addr  in  ADDR_BITS  word address.
- cpu_req_data  in  32  write data.
- cpu_res_data  out  32  read data; valid while cpu_res_ready = 1.
- cpu_res_ready  out  1  one-cycle completion pulse.
- cache_to_mem  out  cache_to_mem_type  fields: addr[ADDR_BITS], data[32], rw, valid.
- mem_to_cache  in  mem_to_cache_type  fields: data[32], ready.

Behaviour:
- Reset (asynchronous, active-low):
  - state = IDLE; all valid and dirty bits = 0.
  - cpu_res_ready = 0, cpu_res_data = 0, cache_to_mem = all 0.
  - Tag and data arrays are not reset.
- Address split: index = addr[INDEX_BITS-1:0], tag = addr[ADDR_BITS-1:INDEX_BITS].
- IDLE:
  - If cpu_req_valid, latch rw/addr/data and go to COMPARE.
  - A request presented while not in IDLE is ignored. The CPU holds off until cpu_res_ready.
- COMPARE, hit (valid[idx] and tag match):
  - Read: cpu_res_data = line.
  - Write: line = latched data, dirty[idx] = 1.
  - Both: cpu_res_ready pulses next cycle, then IDLE.
  - Hit latency: request sampled at edge E, cpu_res_ready high in the cycle after E+1.
- COMPARE, miss:
  - If valid[idx] and dirty[idx]: issue a write {victim tag, idx} with victim data, go to WRITE_BACK.
  - Otherwise: issue a read of the latched addr, go to ALLOCATE.
- WRITE_BACK:
  - Wait for mem_to_cache.ready.
  - Then clear dirty[idx], issue a read of the latched addr, go to ALLOCATE.
- ALLOCATE:
  - Wait for mem_to_cache.ready.
  - Then line = mem_to_cache.data, tag = latched tag, valid = 1, dirty = 0, go to COMPARE.
  - COMPARE now hits; a write miss completes there as a write hit.
- Memory protocol:
  - cache_to_mem.valid is a registered one-cycle pulse per transaction.
  - addr, data and rw are registered and held stable from the pulse until ready is seen.
  - Exactly one transaction is outstanding; no new valid pulse is issued before ready.
  - ready is sampled only in WRITE_BACK/ALLOCATE; ready in any other state is ignored.
  - No timeout; waits indefinitely.
- cpu_res_ready never asserts during a miss before the final COMPARE.
- Reset asserted mid-transaction: state returns to IDLE asynchronously and the transaction is abandoned; cache_to_mem.valid = 0 and cpu_res_ready = 0 immediately; no response is issued; all lines become invalid.
- Index collisions: the same index with a different tag always evicts. Index 0 and index 2^INDEX_BITS-1 behave identically to the others.

Optional Feature:
- Macro DM_CACHE_STATS_EN.
- When defined, adds outputs hit_count[32] and miss_count[32]:
  - Both are 0 on reset.
  - On the first COMPARE of each request, exactly one counter increments: hit on a hit, miss on a miss. The post-refill COMPARE is not counted.
  - Both counters saturate at 0xFFFFFFFF.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset, then read 0x00010; memory returns 0xDEADBEEF. Required: one cache_to_mem.valid pulse (rw=0, addr=0x00010), no write pulse, cpu_res_data=0xDEADBEEF with a single cpu_res_ready pulse.
- Read 0x00010 again. Required: no cache_to_mem.valid pulse, cpu_res_data=0xDEADBEEF, ready in the cycle after COMPARE.
- Write 0x12345678 to 0x00010. Required: hit, no memory traffic; a later read returns 0x12345678.
- Read 0x00410 (same index, INDEX_BITS=10), memory[0x00410]=0xCAFEF00D. Required, in order:
  - Write pulse rw=1, addr=0x00010, data=0x12345678; RAM now holds 0x12345678 at 0x00010.
  - Read pulse addr=0x00410.
  - cpu_res_data=0xCAFEF00D.
- Assert rst during WRITE_BACK. Required: cache_to_mem.valid=0 and state IDLE at once, no cpu_res_ready; after release, a read of 0x00010 misses (read pulse issued, no write-back).
- With DM_CACHE_STATS_EN, run the first four scenarios in sequence. Required: hit_count=3, miss_count=2; force hit_count=0xFFFFFFFF, issue a hit, and it stays 0xFFFFFFFF.
